// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one shift and one trial subtract per quotient bit
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] S,
  input  logic             load_divisor,
  input  logic             load_dividend,
  input  logic             execute,
  output logic [WIDTH-1:0] Qval,
  output logic [WIDTH-1:0] Rval,
  output logic [WIDTH-1:0] Dval,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SUB   = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic [WIDTH+1:0] trial;

  // Extra top bit of the trial difference is the borrow: set means restore.
  assign trial = {1'b0, r} - {2'b00, d};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      r        <= '0;
      q        <= '0;
      d        <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_divisor || load_dividend) begin
            if (load_divisor) d <= S;
            if (load_dividend) begin
              q <= S;
              r <= '0;
            end
          end else if (execute) begin
            r        <= '0;
            cnt      <= '0;
            div_zero <= (d == '0);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {r, q} <= {r[WIDTH-1:0], q, 1'b0};
          state  <= SUB;
        end
        SUB: begin
          if (!trial[WIDTH+1]) begin
            r    <= trial[WIDTH:0];
            q[0] <= 1'b1;
          end
          if (cnt == CNT_LAST) begin
            state <= HOLD;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= SHIFT;
          end
        end
        HOLD: begin
          if (!execute) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Qval = q;
  assign Rval = r[WIDTH-1:0];
  assign Dval = d;
  assign busy = (state == SHIFT) || (state == SUB);
  assign done = (state == HOLD);

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential unsigned restoring divider for the Lab 5 arithmetic unit, the inverse of the shift-add multiplier path. The operator loads divisor and dividend from the switches with buttons, and `execute` starts a division. The block produces the quotient and remainder in WIDTH iterations, two clock cycles per iteration. The FSM, iteration counter, shift registers and subtractor are all contained in this block; the results drive the hex displays.

## Interface
- WIDTH, 8, operand width in bits (quotient, remainder, divisor, switch bus)
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- S  in  WIDTH  switch input, source for divisor and dividend loads
- load_divisor  in  1  level, loads S into the divisor register D
- load_dividend  in  1  level, loads S into the quotient/dividend register Q and clears R
- execute  in  1  level, starts one division
- Qval  out  WIDTH  quotient register Q (holds dividend before a run)
- Rval  out  WIDTH  remainder, R[WIDTH-1:0]
- Dval  out  WIDTH  divisor register D
- busy  out  1  high while a division is in progress
- done  out  1  high in HOLD: results valid and execute not yet released
- div_zero  out  1  set when a run starts with D == 0; cleared at the next run start

## Operation
- Internal registers:
  - R: WIDTH+1 bits.
  - Q, D: WIDTH bits each.
  - cnt: $clog2(WIDTH) bits.
  - state: IDLE, SHIFT, SUB, HOLD.
- Reset (reset_n low, asynchronous): state=IDLE; R, Q, D, cnt = 0; busy = done = div_zero = 0.
- IDLE:
  - load_divisor=1 → D <= S.
  - load_dividend=1 → Q <= S, R <= 0.
  - Both loads high in the same cycle → both loads happen.
  - Any load high → execute is ignored that cycle.
  - execute=1 with no load → R <= 0, cnt <= 0, div_zero <= (D==0), next state SHIFT.
  - The current Q is the dividend, so back-to-back runs chain (the new dividend is the old quotient).
- SHIFT: {R,Q} <= {R,Q} << 1, with Q[0] <= 0. Next state SUB.
- SUB:
  - Trial difference T = {1'b0,R} - {2'b0,D}, WIDTH+2 bits.
  - T sign bit = 0 → R <= T[WIDTH:0], Q[0] <= 1.
  - T sign bit = 1 → R unchanged (restore), Q[0] stays 0.
  - cnt == WIDTH-1 → next state HOLD. Otherwise cnt <= cnt+1 and next state SHIFT.
- HOLD: registers frozen, done=1. When execute=0, next state IDLE. Holding execute high produces exactly one run.
- load_divisor and load_dividend are ignored in SHIFT, SUB and HOLD.
- D == 0 is not special-cased in the datapath: every trial succeeds, giving Q = all ones and R = dividend. div_zero flags this result.
- Width rule: R never exceeds 2*D-1 < 2^(WIDTH+1), so WIDTH+1 bits suffice. Rval = R[WIDTH-1:0] is exact when the run completes.

## Timing
- Start: execute sampled high in IDLE at edge k → busy=1 after edge k.
- Iteration i (i = 0..WIDTH-1): SHIFT executes at edge k+1+2i, SUB at edge k+2+2i.
- Completion: after edge k+2*WIDTH (k+16 for WIDTH=8), state=HOLD, busy=0, done=1, and Qval/Rval are final.
- Latency is 2*WIDTH cycles from the start edge and is independent of operand values.
- busy and done are Moore outputs decoded from state:
  - busy = (SHIFT or SUB).
  - done = HOLD.
- Return to IDLE: in the first cycle in HOLD with execute=0, the next edge returns to IDLE. A new start is possible one edge after that.
- reset_n low mid-run: outputs go to their reset values immediately, without waiting for a clock edge. With reset_n high again, the first edge with execute=1 starts from IDLE.
- Qval, Rval and Dval change only on clock edges, except under asynchronous reset.

## Test plan
- **Basic divide:** D=7, dividend=100, pulse execute → after 16 cycles Qval=14, Rval=2, div_zero=0, done=1.
- **Extremes:**
  - D=1, dividend=255 → Qval=255, Rval=0.
  - D=200, dividend=5 → Qval=0, Rval=5.
  - D=255, dividend=255 → Qval=1, Rval=0.
- **Divide by zero:** D=0, dividend=200 → div_zero=1, Qval=255, Rval=200. A following run with D=3 clears div_zero.
- **Held execute and chaining:**
  - D=7, dividend=100, execute held 40 cycles → exactly one run; busy high for exactly 16 cycles; Qval stays 14.
  - Release execute, press again → Qval=2, Rval=0.
- **Loads while busy:** toggle load_dividend and load_divisor with S=0xAA at cycle 5 of a 100/7 run → ignored; the result is still 14 R 2 and Dval stays 7.
- **Reset mid-run:** pull reset_n low between edges at cycle 6 → Qval, Rval, Dval, busy, done and div_zero read 0 before the next edge, state=IDLE. A fresh 100/7 run after release → 14 R 2.
